// File: rtl/operand_entry_if.sv
// Raw switch/button inputs and captured operand outputs of the operand entry stage.
interface operand_entry_if;
    logic [9:0] sw_in;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] op_q;
    logic       operands_valid;
    logic       load_pulse;
    logic [9:0] sw_stable;

    modport master (
        output sw_in, btn_enter, btn_clear,
        input  a_q, b_q, op_q, operands_valid, load_pulse, sw_stable
    );

    modport slave (
        input  sw_in, btn_enter, btn_clear,
        output a_q, b_q, op_q, operands_valid, load_pulse, sw_stable
    );
endinterface

// File: rtl/operand_entry.sv
// Synchronizes and debounces the operand switches and buttons, then latches A/B/opcode
// on an enter press so the downstream ALU and display only change on an explicit load.
module operand_entry_debounce #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync_p0;
    logic [W-1:0]     sync_p1;
    logic [W-1:0]     prev_p2;
    logic [W-1:0]     level_q;
    logic [CNT_W-1:0] cnt;

    // Stage p0/p1: two-flop synchronizer; p2: previous synced sample for glitch detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= '0;
            level_q <= '0;
            cnt     <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            if (sync_p1 == level_q || sync_p1 != prev_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= sync_p1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
endmodule

module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic           clk,
    input logic           reset,
    operand_entry_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] sw_deb;
    logic       enter_deb;
    logic       clear_deb;
    logic       enter_prev;
    logic       clear_prev;
    logic       enter_press;
    logic       clear_press;
    logic       capture;
    logic       zero;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [1:0] op_r;

    // The switch bus debounces as one unit so a capture never mixes old and new bits.
    operand_entry_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.sw_in),
        .level (sw_deb)
    );

    operand_entry_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_enter),
        .level (enter_deb)
    );

    operand_entry_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_clear),
        .level (clear_deb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            enter_prev <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            enter_prev <= enter_deb;
            clear_prev <= clear_deb;
        end
    end

    assign enter_press = enter_deb & ~enter_prev;
    assign clear_press = clear_deb & ~clear_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear outranks enter in every state; LOAD ignores enter for its single cycle.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        zero       = 1'b0;
        if (clear_press) begin
            state_next = IDLE;
            zero       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (enter_press) begin
                        capture    = 1'b1;
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    state_next = HOLD;
                end
                HOLD: begin
                    if (enter_press) begin
                        capture    = 1'b1;
                        state_next = LOAD;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || zero) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= '0;
        end else if (capture) begin
            a_r  <= sw_deb[3:0];
            b_r  <= sw_deb[7:4];
            op_r <= sw_deb[9:8];
        end
    end

    assign bus.a_q            = a_r;
    assign bus.b_q            = b_r;
    assign bus.op_q           = op_r;
    assign bus.operands_valid = (state != IDLE);
    assign bus.load_pulse     = (state == LOAD);
    assign bus.sw_stable      = sw_deb;
endmodule
